// File: rtl/alu_op_responder_if.sv
// rtl/alu_op_responder_if.sv - start/operand/result handshake bundle between term accumulator and ALU responder
//
// Purpose: groups the four operation strobes, the two operands, the four result/ready
// pairs and busy. The consumer (term accumulator) uses modport master; the responder
// uses modport slave.
//
// Signals:
//   add_start, mult_start, divide_start, exponent_start  master->slave  operation strobes
//   operand_a, operand_b                                 master->slave  DATA_WIDTH operands
//   add_result, mult_result, divide_result,
//   exponent_result                                      slave->master  DATA_WIDTH results, zero unless ready
//   add_data_ready, mult_data_ready, divide_data_ready,
//   exponent_data_ready                                  slave->master  one-cycle completion pulses
//   busy                                                 slave->master  accepted and not yet retired
interface alu_op_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  add_start;
    logic                  mult_start;
    logic                  divide_start;
    logic                  exponent_start;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic [DATA_WIDTH-1:0] add_result;
    logic [DATA_WIDTH-1:0] mult_result;
    logic [DATA_WIDTH-1:0] divide_result;
    logic [DATA_WIDTH-1:0] exponent_result;
    logic                  add_data_ready;
    logic                  mult_data_ready;
    logic                  divide_data_ready;
    logic                  exponent_data_ready;
    logic                  busy;

    modport master (
        output add_start, mult_start, divide_start, exponent_start,
        output operand_a, operand_b,
        input  add_result, mult_result, divide_result, exponent_result,
        input  add_data_ready, mult_data_ready, divide_data_ready, exponent_data_ready,
        input  busy
    );

    modport slave (
        input  add_start, mult_start, divide_start, exponent_start,
        input  operand_a, operand_b,
        output add_result, mult_result, divide_result, exponent_result,
        output add_data_ready, mult_data_ready, divide_data_ready, exponent_data_ready,
        output busy
    );
endinterface

// File: rtl/alu_op_responder.sv
// rtl/alu_op_responder.sv - iterative fixed-point add/mult/divide/power responder
//
// Purpose: accepts one operation strobe while idle, computes the result iteratively on a
// shared shift-add / restoring-divide datapath and returns it with a one-cycle ready pulse
// on the matching result port. Result ports are zero whenever their ready is low so the
// consumer can OR all four pairs together.
//
// Ports:
//   clock  input   system clock
//   reset  input   asynchronous active-high reset
//   alu    slave   alu_op_responder_if: strobes and operands in, results/readies/busy out
//
// Configuration macro: ALU_SATURATION_EN
//   defined   - add, mult and exponent results clamp to the signed extremes on overflow
//   undefined - those results wrap to the low DATA_WIDTH bits
module alu_op_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int EXP_MAX_N  = 31
) (
    input  logic                clock,
    input  logic                reset,
    alu_op_responder_if.slave   alu
);
    localparam int DW = DATA_WIDTH;
    localparam int FB = FRAC_BITS;
    localparam int QW = DATA_WIDTH + FRAC_BITS;   // divide dividend/quotient width
    localparam int NW = $clog2(EXP_MAX_N + 1);
    localparam int CW = $clog2(QW + 1);

    localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] ONE     = {{(DW-1){1'b0}}, 1'b1} << FB;

`ifdef ALU_SATURATION_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ADD, S_MUL, S_DIV, S_EXP_SQ, S_EXP_MUL, S_FIN, S_DONE
    } state_t;

    typedef enum logic [1:0] {OP_ADD, OP_MUL, OP_DIV, OP_EXP} op_t;

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic            neg_q, neg_d;       // result sign of the running mult/divide
    logic [DW-1:0]   mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic [DW-1:0]   hi_q, hi_d;         // product high half or partial remainder
    logic [QW-1:0]   lo_q, lo_d;         // multiplier/product low half, or dividend/quotient
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   base_q, base_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DW-1:0]   res_q, res_d;

    function automatic logic [DW-1:0] abs_val(input logic [DW-1:0] x);
        // MIN_NEG maps to itself, which reads correctly as the unsigned magnitude 2^(DW-1)
        return x[DW-1] ? -x : x;
    endfunction

    function automatic logic [DW-1:0] add_final(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW:0]   s;
        logic [DW-1:0] r;
        s = {x[DW-1], x} + {y[DW-1], y};
        r = s[DW-1:0];
        if (SAT_EN && (s[DW] != s[DW-1]))
            r = s[DW] ? MIN_NEG : MAX_POS;
        return r;
    endfunction

    // Magnitude product -> drop fraction bits (toward zero) -> re-sign -> clamp or wrap
    function automatic logic [DW-1:0] mul_final(input logic [2*DW-1:0] prod, input logic neg);
        logic [2*DW-1:0] mag;
        logic [DW-1:0]   r;
        mag = prod >> FB;
        r   = neg ? -mag[DW-1:0] : mag[DW-1:0];
        if (SAT_EN && !neg && (mag > {{DW{1'b0}}, MAX_POS}))
            r = MAX_POS;
        else if (SAT_EN && neg && (mag > {{DW{1'b0}}, MIN_NEG}))
            r = MIN_NEG;
        return r;
    endfunction

    // Shift-add step: add multiplicand into the high half when the current multiplier
    // bit is set, then shift the whole product right one place.
    logic [DW:0]     mul_sum;
    logic [DW-1:0]   mul_res;
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_res = mul_final({hi_q, lo_q[DW-1:0]}, neg_q);

    // Restoring divide step: shift next dividend bit into the remainder and subtract if it fits.
    logic [DW:0]     div_rem;
    logic            div_ge;
    logic [DW-1:0]   div_res;
    assign div_rem = {hi_q, lo_q[QW-1]};
    assign div_ge  = (div_rem >= {1'b0, mcand_q});
    assign div_res = neg_q ? -lo_q[DW-1:0] : lo_q[DW-1:0];

    // Integer exponent taken from operand_b: negative -> 0, otherwise clamp to EXP_MAX_N
    logic [DW-1:0]   b_int;
    logic [NW-1:0]   n_start;
    always_comb begin
        b_int = alu.operand_b >> FB;
        if (alu.operand_b[DW-1])
            n_start = '0;
        else if (b_int > DW'(EXP_MAX_N))
            n_start = NW'(EXP_MAX_N);
        else
            n_start = b_int[NW-1:0];
    end

    logic [NW-1:0]   n_shift;
    assign n_shift = n_q >> 1;

    // Multiply loader: any branch that starts a new multiply sets ld_en and the operands
    logic            ld_en;
    logic [DW-1:0]   ld_x;
    logic [DW-1:0]   ld_y;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        acc_d   = acc_q;
        n_d     = n_q;
        res_d   = res_q;
        ld_en   = 1'b0;
        ld_x    = '0;
        ld_y    = '0;

        case (state_q)
            S_IDLE: begin
                a_d = alu.operand_a;
                b_d = alu.operand_b;
                if (alu.add_start) begin
                    op_d    = OP_ADD;
                    state_d = S_ADD;
                end else if (alu.mult_start) begin
                    op_d    = OP_MUL;
                    ld_en   = 1'b1;
                    ld_x    = alu.operand_a;
                    ld_y    = alu.operand_b;
                    state_d = S_MUL;
                end else if (alu.divide_start) begin
                    op_d    = OP_DIV;
                    neg_d   = alu.operand_a[DW-1] ^ alu.operand_b[DW-1];
                    mcand_d = abs_val(alu.operand_b);
                    hi_d    = '0;
                    lo_d    = {abs_val(alu.operand_a), {FB{1'b0}}};
                    cnt_d   = '0;
                    // Divide-by-zero skips the iterations; FIN picks the signed extreme
                    state_d = (alu.operand_b == '0) ? S_FIN : S_DIV;
                end else if (alu.exponent_start) begin
                    op_d   = OP_EXP;
                    base_d = alu.operand_a;
                    acc_d  = ONE;
                    n_d    = n_start;
                    if (n_start == '0) begin
                        state_d = S_FIN;
                    end else if (n_start[0]) begin
                        ld_en   = 1'b1;
                        ld_x    = ONE;
                        ld_y    = alu.operand_a;
                        state_d = S_EXP_MUL;
                    end else begin
                        ld_en   = 1'b1;
                        ld_x    = alu.operand_a;
                        ld_y    = alu.operand_a;
                        state_d = S_EXP_SQ;
                    end
                end
            end

            S_ADD: begin
                res_d   = add_final(a_q, b_q);
                state_d = S_DONE;
            end

            S_MUL: begin
                hi_d  = mul_sum[DW:1];
                lo_d  = {lo_q[QW-1:DW], mul_sum[0], lo_q[DW-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1))
                    state_d = S_FIN;
            end

            S_DIV: begin
                hi_d  = div_ge ? DW'(div_rem - {1'b0, mcand_q}) : div_rem[DW-1:0];
                lo_d  = {lo_q[QW-2:0], div_ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(QW - 1))
                    state_d = S_FIN;
            end

            // acc *= base for a set exponent bit; the cycle after the last shift-add step
            // writes the product back and chooses the next multiply.
            S_EXP_MUL: begin
                if (cnt_q != CW'(DW)) begin
                    hi_d  = mul_sum[DW:1];
                    lo_d  = {lo_q[QW-1:DW], mul_sum[0], lo_q[DW-1:1]};
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    acc_d = mul_res;
                    if (n_shift == '0) begin
                        state_d = S_FIN;
                    end else begin
                        ld_en   = 1'b1;
                        ld_x    = base_q;
                        ld_y    = base_q;
                        state_d = S_EXP_SQ;
                    end
                end
            end

            // base *= base, then move to the next exponent bit. Only entered while higher
            // exponent bits remain, so the final useless square is never computed.
            S_EXP_SQ: begin
                if (cnt_q != CW'(DW)) begin
                    hi_d  = mul_sum[DW:1];
                    lo_d  = {lo_q[QW-1:DW], mul_sum[0], lo_q[DW-1:1]};
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    base_d = mul_res;
                    n_d    = n_shift;
                    ld_en  = 1'b1;
                    ld_y   = mul_res;
                    if (n_shift[0]) begin
                        ld_x    = acc_q;
                        state_d = S_EXP_MUL;
                    end else begin
                        ld_x    = mul_res;
                        state_d = S_EXP_SQ;
                    end
                end
            end

            S_FIN: begin
                case (op_q)
                    OP_MUL:  res_d = mul_res;
                    OP_DIV:  res_d = (mcand_q == '0) ? (a_q[DW-1] ? MIN_NEG : MAX_POS) : div_res;
                    OP_EXP:  res_d = acc_q;
                    default: res_d = res_q;
                endcase
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ld_en) begin
            mcand_d = abs_val(ld_x);
            lo_d    = {{FB{1'b0}}, abs_val(ld_y)};
            hi_d    = '0;
            neg_d   = ld_x[DW-1] ^ ld_y[DW-1];
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            acc_q   <= '0;
            n_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            res_q   <= res_d;
        end
    end

    logic in_done;
    assign in_done = (state_q == S_DONE);

    assign alu.add_data_ready      = in_done && (op_q == OP_ADD);
    assign alu.mult_data_ready     = in_done && (op_q == OP_MUL);
    assign alu.divide_data_ready   = in_done && (op_q == OP_DIV);
    assign alu.exponent_data_ready = in_done && (op_q == OP_EXP);

    assign alu.add_result      = alu.add_data_ready      ? res_q : '0;
    assign alu.mult_result     = alu.mult_data_ready     ? res_q : '0;
    assign alu.divide_result   = alu.divide_data_ready   ? res_q : '0;
    assign alu.exponent_result = alu.exponent_data_ready ? res_q : '0;

    assign alu.busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_op_responder.sv
// tb/tb_alu_op_responder.sv - randomized self-checking bench for alu_op_responder against a fixed-point model
module tb_alu_op_responder;
    localparam int DW        = 32;
    localparam int FB        = 16;
    localparam int EXP_MAX_N = 31;
    localparam int EXP_BOUND = 2 * $clog2(EXP_MAX_N + 1) * (DW + 1) + 2;

`ifdef ALU_SATURATION_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_op_responder_if #(.DATA_WIDTH(DW)) bus ();

    alu_op_responder #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB),
        .EXP_MAX_N  (EXP_MAX_N)
    ) dut (
        .clock (clk),
        .reset (rst),
        .alu   (bus)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    // ---------------- reference model: plain signed arithmetic ----------------
    function automatic logic [31:0] fit(input longint v);
        logic [63:0] w;
        if (SAT && v > 64'sd2147483647)  return 32'h7FFFFFFF;
        if (SAT && v < -64'sd2147483648) return 32'h80000000;
        w = v;
        return w[31:0];
    endfunction

    function automatic longint sval(input logic [31:0] x);
        return longint'($signed(x));
    endfunction

    function automatic longint mag(input logic [31:0] x);
        longint s;
        s = sval(x);
        return (s < 0) ? -s : s;
    endfunction

    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
        return fit(sval(a) + sval(b));
    endfunction

    function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = (mag(a) * mag(b)) / 65536;
        return fit((a[31] ^ b[31]) ? -p : p);
    endfunction

    function automatic logic [31:0] m_div(input logic [31:0] a, input logic [31:0] b);
        longint q;
        logic [63:0] w;
        if (b == 32'h0) return a[31] ? 32'h80000000 : 32'h7FFFFFFF;
        q = (mag(a) * 65536) / mag(b);
        w = (a[31] ^ b[31]) ? -q : q;
        return w[31:0];
    endfunction

    function automatic int m_exp_n(input logic [31:0] b);
        longint k;
        if (sval(b) < 0) return 0;
        k = sval(b) / 65536;
        return (k > EXP_MAX_N) ? EXP_MAX_N : int'(k);
    endfunction

    function automatic logic [31:0] m_exp(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] acc;
        logic [31:0] base;
        int n;
        n    = m_exp_n(b);
        acc  = 32'h00010000;
        base = a;
        while (n != 0) begin
            if (n % 2 == 1) acc = m_mul(acc, base);
            n = n / 2;
            if (n != 0) base = m_mul(base, base);
        end
        return acc;
    endfunction

    function automatic logic [31:0] m_result(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0:       return m_add(a, b);
            1:       return m_mul(a, b);
            2:       return m_div(a, b);
            default: return m_exp(a, b);
        endcase
    endfunction

    // -1 means "variable, only bounded"
    function automatic int m_latency(input int op, input logic [31:0] b);
        case (op)
            0:       return 2;
            1:       return DW + 2;
            2:       return (b == 32'h0) ? 2 : DW + FB + 2;
            default: return (m_exp_n(b) == 0) ? 2 : -1;
        endcase
    endfunction

    // ---------------- DUT observation helpers ----------------
    function automatic logic [3:0] readies();
        return {bus.exponent_data_ready, bus.divide_data_ready, bus.mult_data_ready, bus.add_data_ready};
    endfunction

    function automatic logic [31:0] result_of(input int op);
        case (op)
            0:       return bus.add_result;
            1:       return bus.mult_result;
            2:       return bus.divide_result;
            default: return bus.exponent_result;
        endcase
    endfunction

    function automatic logic [31:0] others_or(input int op);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (i != op) r = r | result_of(i);
        return r;
    endfunction

    task automatic drive_starts(input logic [3:0] s);
        bus.add_start      = s[0];
        bus.mult_start     = s[1];
        bus.divide_start   = s[2];
        bus.exponent_start = s[3];
    endtask

    // Issue one request (starts mask, expected winning op), wait for its ready pulse
    // within a cycle budget and check value, exclusivity, latency and retirement.
    // poke > 0 re-asserts mult_start in that busy cycle; it must be ignored.
    task automatic run_op(input string tag, input logic [3:0] starts, input int op,
                          input logic [31:0] a, input logic [31:0] b, input int poke,
                          output logic [31:0] res);
        logic [31:0] want;
        int          want_lat;
        int          lat;
        bit          seen;
        want     = m_result(op, a, b);
        want_lat = m_latency(op, b);
        @(negedge clk);
        bus.operand_a = a;
        bus.operand_b = b;
        drive_starts(starts);
        @(posedge clk);
        lat  = 1;
        seen = 1'b0;
        while (lat <= EXP_BOUND + 10) begin
            @(negedge clk);
            drive_starts(4'b0000);
            if (lat == 1) expect_eq({tag, "_busy"}, 64'(bus.busy), 64'd1);
            if (readies() != 4'b0000) begin
                seen = 1'b1;
                break;
            end
            if (lat == poke) begin
                bus.mult_start = 1'b1;
                bus.operand_a  = $urandom;
                bus.operand_b  = $urandom;
            end
            @(posedge clk);
            lat++;
        end
        expect_eq({tag, "_ready_seen"}, 64'(seen), 64'd1);
        res = '0;
        if (seen) begin
            res = result_of(op);
            expect_eq({tag, "_ready_onehot"}, 64'(readies()), 64'(4'b0001 << op));
            expect_eq({tag, "_result"}, 64'(res), 64'(want));
            expect_eq({tag, "_others_zero"}, 64'(others_or(op)), 64'd0);
            expect_eq({tag, "_busy_at_ready"}, 64'(bus.busy), 64'd1);
            if (want_lat >= 0)
                expect_eq({tag, "_latency"}, 64'(lat), 64'(want_lat));
            else
                expect_eq({tag, "_latency_bound"}, 64'(lat <= EXP_BOUND), 64'd1);
            @(negedge clk);
            expect_eq({tag, "_ready_one_cycle"}, 64'(readies()), 64'd0);
            expect_eq({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
            expect_eq({tag, "_results_cleared"}, 64'(others_or(-1)), 64'd0);
        end
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (readies() != 4'b0000) pulses++;
        end
        expect_eq(tag, 64'(pulses), 64'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        if ($urandom_range(0, 1) == 0) return $urandom;
        v = $urandom_range(0, 32'h0007FFFF);
        return ($urandom_range(0, 1) == 0) ? v : -v;
    endfunction

    logic [31:0] r;

    initial begin
        drive_starts(4'b0000);
        bus.operand_a = '0;
        bus.operand_b = '0;

        repeat (2) @(posedge clk);
        #1;
        expect_eq("reset_busy", 64'(bus.busy), 64'd0);
        expect_eq("reset_readies", 64'(readies()), 64'd0);
        expect_eq("reset_results", 64'(others_or(-1)), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("tp_add", 4'b0001, 0, 32'h00018000, 32'h00020000, -1, r);
        expect_eq("tp_add_value", 64'(r), 64'h00038000);

        run_op("tp_mul", 4'b0010, 1, 32'h00018000, 32'hFFFE0000, 5, r);
        expect_eq("tp_mul_value", 64'(r), 64'hFFFD0000);
        watch_quiet("tp_mul_busy_start_ignored", 40);

        run_op("tp_div", 4'b0100, 2, 32'h00030000, 32'h00020000, -1, r);
        expect_eq("tp_div_value", 64'(r), 64'h00018000);
        run_op("tp_div0", 4'b0100, 2, 32'hFFFD0000, 32'h00000000, -1, r);
        expect_eq("tp_div0_value", 64'(r), 64'h80000000);

        run_op("tp_exp", 4'b1000, 3, 32'h00018000, 32'h00030000, -1, r);
        expect_eq("tp_exp_value", 64'(r), 64'h00036000);
        run_op("tp_exp_neg_n", 4'b1000, 3, 32'h00018000, 32'hFFFF0000, -1, r);
        expect_eq("tp_exp_neg_n_value", 64'(r), 64'h00010000);

        run_op("tp_add_ovf", 4'b0001, 0, 32'h7FFF0000, 32'h00020000, -1, r);
        expect_eq("tp_add_ovf_value", 64'(r), SAT ? 64'h7FFFFFFF : 64'h80010000);

        // Reset in the middle of a divide
        @(negedge clk);
        bus.operand_a = 32'h00030000;
        bus.operand_b = 32'h00020000;
        drive_starts(4'b0100);
        @(posedge clk);
        @(negedge clk);
        drive_starts(4'b0000);
        repeat (19) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        expect_eq("rst_mid_div_busy", 64'(bus.busy), 64'd0);
        expect_eq("rst_mid_div_readies", 64'(readies()), 64'd0);
        expect_eq("rst_mid_div_results", 64'(others_or(-1)), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        watch_quiet("rst_no_stray_ready", 60);

        run_op("tp_simul", 4'b0011, 0, 32'h00050000, 32'hFFFF8000, -1, r);
        expect_eq("tp_simul_value", 64'(r), 64'h00048000);
        watch_quiet("tp_simul_mult_dropped", 40);

        for (int i = 0; i < 40; i++) begin
            int          op;
            logic [3:0]  starts;
            logic [31:0] a;
            logic [31:0] b;
            op     = $urandom_range(0, 3);
            starts = (4'b0001 << op) | (4'($urandom_range(0, 15)) & ~((4'b0010 << op) - 4'b0001));
            a      = rand_operand();
            b      = rand_operand();
            if (op == 2 && $urandom_range(0, 7) == 0) b = 32'h0;
            if (op == 3) begin
                if ($urandom_range(0, 3) != 0) begin
                    a = $urandom_range(32'h00004000, 32'h0001C000);
                    if ($urandom_range(0, 1) == 0) a = -a;
                end
                b = ($urandom_range(0, 40) << 16) | $urandom_range(0, 16'hFFFF);
                if ($urandom_range(0, 5) == 0) b = -b;
            end
            run_op("rnd", starts, op, a, b, -1, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/alu_op_responder.md
Name: alu_op_responder

Overview:
- Shared fixed-point arithmetic responder on the ALU side of the start/operand/data_ready handshake driven by the term accumulator.
- Accepts one operation strobe (add, mult, divide, exponent) with operand_a/operand_b.
- Computes the result iteratively and returns it on the matching result port with a one-cycle data_ready pulse.
- Result ports are zero whenever not ready, because the consumer ORs all four result/ready pairs together.

Parameters:
DATA_WIDTH, 32, operand/result width, signed two's complement fixed point
FRAC_BITS, 16, fractional bits (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS)
EXP_MAX_N, 31, maximum integer exponent; larger values are clamped

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
add_start  input  1  request add (a+b)
mult_start  input  1  request multiply (a*b)
divide_start  input  1  request divide (a/b)
exponent_start  input  1  request power (a^n, n = integer part of b)
operand_a  input  DATA_WIDTH  first operand, sampled with start
operand_b  input  DATA_WIDTH  second operand, sampled with start
add_result  output  DATA_WIDTH  add result; zero unless add_data_ready
mult_result  output  DATA_WIDTH  multiply result; zero unless mult_data_ready
divide_result  output  DATA_WIDTH  quotient; zero unless divide_data_ready
exponent_result  output  DATA_WIDTH  power result; zero unless exponent_data_ready
add_data_ready  output  1  one-cycle completion pulse
mult_data_ready  output  1  one-cycle completion pulse
divide_data_ready  output  1  one-cycle completion pulse
exponent_data_ready  output  1  one-cycle completion pulse
busy  output  1  high from acceptance until the ready pulse, inclusive

Behaviour:
- Reset (async, any state): state=IDLE; all results, ready flags and busy are 0; internal operand, accumulator and counter registers are cleared.
- Starts are sampled only in IDLE. Any start seen in a non-IDLE state is ignored and no request is queued.
- Simultaneous starts: priority add > mult > divide > exponent; the lower-priority requests are dropped.
- Acceptance at edge k latches the operands and moves the FSM out of IDLE. busy goes high after edge k.
- States:
  - IDLE
  - ADD: 1 cycle
  - MUL: DATA_WIDTH cycles, shift-add, 1 bit/cycle
  - DIV: DATA_WIDTH+FRAC_BITS cycles, restoring, 1 quotient bit/cycle
  - EXP_SQ / EXP_MUL: square-and-multiply using the shared MUL datapath
  - DONE: 1 cycle, then back to IDLE
- Only one *_data_ready is high, and only in DONE. The matching result is valid only in that cycle; all other result ports are 0.
- Latency from the start edge to the ready-high cycle:
  - add: 2 cycles
  - mult: DATA_WIDTH+2 cycles
  - divide: DATA_WIDTH+FRAC_BITS+2 cycles
  - exponent n=0: 2 cycles
  - exponent n>0: variable, bounded by (2*ceil(log2(EXP_MAX_N+1)))*(DATA_WIDTH+1)+2 cycles
- Mult:
  - Sign-magnitude: result sign = a[MSB]^b[MSB].
  - 2*DATA_WIDTH magnitude product shifted right by FRAC_BITS (truncate toward zero), then re-signed.
- Divide:
  - Computes (|a|<<FRAC_BITS)/|b|; the sign rule is the same as mult; truncates toward zero.
  - b==0 skips iteration (latency 2) and returns the signed extreme: 0x7FFFFFFF if a>=0, else 0x80000000.
- Exponent:
  - n = 0 if b is negative, else b>>FRAC_BITS clamped to EXP_MAX_N.
  - Accumulator starts at ONE = 1<<FRAC_BITS. Exponent bits are processed LSB first.
  - Each multiply step follows the mult rules, including overflow handling.
- Overflow handling follows the ALU_SATURATION_EN section.
- A start asserted in the DONE cycle is ignored. The consumer must re-request after ready.

Optional Feature:
ALU_SATURATION_EN
- Defined: add, mult and exponent results that exceed the range clamp to 0x7FFFFFFF (positive) or 0x80000000 (negative).
- Undefined: results wrap, keeping the low DATA_WIDTH bits of the true two's-complement result.
- Divide-by-zero returns the signed extreme in both builds.

Test Plan:
- Add: 1-cycle pulse add_start, a=0x00018000, b=0x00020000 -> add_data_ready 2 cycles later, add_result=0x00038000, other results 0.
- Mult: a=0x00018000, b=0xFFFE0000 (-2.0) -> mult_result=0xFFFD0000 at cycle DATA_WIDTH+2; a second mult_start at cycle 5 is ignored.
- Divide: a=0x00030000, b=0x00020000 -> divide_result=0x00018000 at cycle 50; a=0xFFFD0000, b=0 -> 0x80000000 at cycle 2.
- Exponent: a=0x00018000, b=0x00030000 -> exponent_result=0x00036000; b=0xFFFF0000 -> 0x00010000 at cycle 2.
- Overflow: add a=0x7FFF0000, b=0x00020000 -> 0x7FFFFFFF with ALU_SATURATION_EN, 0x80010000 without.
- Reset and simultaneous starts:
  - Assert reset during DIV cycle 20 -> all outputs 0 immediately; no stray ready pulse after release.
  - Then add_start and mult_start together -> only add_data_ready pulses.
